// File: rtl/escalonador_display_pkg.sv
// Shared types and constants for the multiplexed 4-digit display scheduler.
package escalonador_display_pkg;

  localparam int unsigned SEG_W      = 7;
  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned IDX_W      = 2;
  localparam int unsigned BUS_W      = SEG_W * NUM_DIGITS;

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_ALERT  = 1'b1
  } state_e;

  // Extract the 7-bit field for one digit from a packed 4-digit bus.
  function automatic logic [SEG_W-1:0] pick_digit(input logic [BUS_W-1:0] bus,
                                                  input logic [IDX_W-1:0] idx);
    return bus[32'(idx) * SEG_W +: SEG_W];
  endfunction

  // Active-low one-cold digit enable.
  function automatic logic [NUM_DIGITS-1:0] digit_select(input logic [IDX_W-1:0] idx);
    return ~(NUM_DIGITS'(1) << idx);
  endfunction

endpackage

// File: rtl/escalonador_display_scan_timer.sv
// Slot counter, digit index and frame tick for the display scan.
module scan_timer
  import escalonador_display_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 1000,
  parameter int unsigned CNT_W    = 10
) (
  input  logic             clock,
  input  logic             reset,
  output logic [CNT_W-1:0] slot_nxt_c,
  output logic [IDX_W-1:0] idx_nxt_c,
  output logic             slot_wrap_c,
  output logic             frame_wrap_c,
  output logic             frame_tick
);

  logic [CNT_W-1:0] slot_q, slot_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             frame_tick_q, frame_tick_d;

  // Next-value outputs let the top register digit/segment data aligned with the counter.
  always_comb begin
    slot_wrap_c  = (slot_q == CNT_W'(SCAN_DIV - 1));
    frame_wrap_c = slot_wrap_c && (idx_q == IDX_W'(NUM_DIGITS - 1));
    slot_d       = slot_wrap_c ? '0 : slot_q + CNT_W'(1);
    idx_d        = slot_wrap_c ? idx_q + IDX_W'(1) : idx_q;
    frame_tick_d = frame_wrap_c;
  end

  assign slot_nxt_c = slot_d;
  assign idx_nxt_c  = idx_d;
  assign frame_tick = frame_tick_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      slot_q       <= '0;
      idx_q        <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      slot_q       <= slot_d;
      idx_q        <= idx_d;
      frame_tick_q <= frame_tick_d;
    end
  end

endmodule

// File: rtl/escalonador_display.sv
// 4-digit multiplexed display scheduler with frame-aligned alert override and blinking.
module escalonador_display
  import escalonador_display_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned BLANK        = 16,
  parameter int unsigned ALERT_FRAMES = 250,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [BUS_W-1:0]      norm_seg,
  input  logic [BUS_W-1:0]      alert_seg,
  input  logic                  alert_req,
  input  logic                  blink_en,
  output logic [NUM_DIGITS-1:0] digito,
  output logic [SEG_W-1:0]      segmentos,
  output logic                  source,
  output logic                  alert_ack,
  output logic                  frame_tick
);

  localparam int unsigned CNT_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned FCNT_W = (ALERT_FRAMES > 1) ? $clog2(ALERT_FRAMES) : 1;
  localparam int unsigned BCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CNT_W-1:0] slot_nxt_c;
  logic [IDX_W-1:0] idx_nxt_c;
  logic             slot_wrap_c;
  logic             frame_wrap_c;

  state_e                state_q, state_d;
  logic                  pending_q, pending_d;
  logic [FCNT_W-1:0]     fcnt_q, fcnt_d;
  logic [BUS_W-1:0]      alert_lat_q, alert_lat_d;
  logic                  phase_q, phase_d;
  logic [BCNT_W-1:0]     bcnt_q, bcnt_d;
  logic                  blank_frame_q, blank_frame_d;
  logic                  init_q, init_d;
  logic [NUM_DIGITS-1:0] dig_q, dig_d;
  logic [SEG_W-1:0]      seg_q, seg_d;
  logic                  source_q, source_d;
  logic                  ack_q, ack_d;

  scan_timer #(
    .SCAN_DIV(SCAN_DIV),
    .CNT_W   (CNT_W)
  ) u_scan_timer (
    .clock       (clock),
    .reset       (reset),
    .slot_nxt_c  (slot_nxt_c),
    .idx_nxt_c   (idx_nxt_c),
    .slot_wrap_c (slot_wrap_c),
    .frame_wrap_c(frame_wrap_c),
    .frame_tick  (frame_tick)
  );

  // Alert/blink decisions are taken only on the frame-wrap cycle, so a frame never mixes sources.
  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q | alert_req;
    fcnt_d        = fcnt_q;
    alert_lat_d   = alert_lat_q;
    phase_d       = phase_q;
    bcnt_d        = bcnt_q;
    blank_frame_d = blank_frame_q;
    init_d        = 1'b0;
    seg_d         = seg_q;
    ack_d         = 1'b0;

    if (frame_wrap_c) begin
      if (pending_q) begin
        state_d     = ST_ALERT;
        fcnt_d      = '0;
        alert_lat_d = alert_seg;
        ack_d       = 1'b1;
        pending_d   = alert_req;
      end else if (state_q == ST_ALERT) begin
        if (fcnt_q == FCNT_W'(ALERT_FRAMES - 1)) begin
          state_d = ST_NORMAL;
          fcnt_d  = '0;
        end else begin
          fcnt_d = fcnt_q + FCNT_W'(1);
        end
      end

      if (!blink_en) begin
        phase_d = 1'b1;
        bcnt_d  = '0;
      end else if (bcnt_q == BCNT_W'(BLINK_FRAMES - 1)) begin
        phase_d = ~phase_q;
        bcnt_d  = '0;
      end else begin
        bcnt_d = bcnt_q + BCNT_W'(1);
      end

      blank_frame_d = (state_d == ST_NORMAL) && !phase_d;
    end

    // First cycle after reset loads digit 0 while it is still blanked.
    if (init_q) begin
      seg_d = pick_digit(norm_seg, IDX_W'(0));
    end else if (slot_wrap_c) begin
      seg_d = pick_digit((state_d == ST_ALERT) ? alert_lat_d : norm_seg, idx_nxt_c);
    end

    dig_d    = ((slot_nxt_c < CNT_W'(BLANK)) || blank_frame_d) ? '1 : digit_select(idx_nxt_c);
    source_d = (state_d == ST_ALERT);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_NORMAL;
      pending_q     <= 1'b0;
      fcnt_q        <= '0;
      alert_lat_q   <= '0;
      phase_q       <= 1'b1;
      bcnt_q        <= '0;
      blank_frame_q <= 1'b0;
      init_q        <= 1'b1;
      dig_q         <= '1;
      seg_q         <= '0;
      source_q      <= 1'b0;
      ack_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      fcnt_q        <= fcnt_d;
      alert_lat_q   <= alert_lat_d;
      phase_q       <= phase_d;
      bcnt_q        <= bcnt_d;
      blank_frame_q <= blank_frame_d;
      init_q        <= init_d;
      dig_q         <= dig_d;
      seg_q         <= seg_d;
      source_q      <= source_d;
      ack_q         <= ack_d;
    end
  end

  assign digito    = dig_q;
  assign segmentos = seg_q;
  assign source    = source_q;
  assign alert_ack = ack_q;

endmodule

// File: doc/escalonador_display.md
ESCALONADOR_DISPLAY -- requirements
Module: escalonador_display

Interface
REQ-001 Parameter SCAN_DIV, default 1000, clock cycles per digit slot (>= BLANK+2).
REQ-002 Parameter BLANK, default 16, blanked cycles at start of each slot (anti-ghosting).
REQ-003 Parameter ALERT_FRAMES, default 250, frames an accepted alert is held on display.
REQ-004 Parameter BLINK_FRAMES, default 64, frames per blink half-period.
REQ-005 clock  in  1  single system clock, rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 norm_seg  in  28  normal content, 7 bits per digit, [6:0]=digit 0 (units) ... [27:21]=digit 3.
REQ-008 alert_seg  in  28  alert content, same packing.
REQ-009 alert_req  in  1  alert request, level or pulse; sampled every cycle.
REQ-010 blink_en  in  1  enables blinking of normal content.
REQ-011 digito  out  4  digit select, active-low, at most one bit low.
REQ-012 segmentos  out  7  segment pattern for the selected digit, polarity passed through.
REQ-013 source  out  1  0 = normal content shown, 1 = alert content shown.
REQ-014 alert_ack  out  1  one-cycle pulse when a pending alert is accepted.
REQ-015 frame_tick  out  1  one-cycle pulse at each frame boundary.

Function
REQ-016 Slot counter SHALL count 0..SCAN_DIV-1 and wrap; at wrap the digit index SHALL advance 0->1->2->3->0.
REQ-017 Frame boundary SHALL be the cycle the digit index wraps 3->0; frame_tick SHALL be high exactly that cycle.
REQ-018 During slot cycles 0..BLANK-1 digito SHALL be 4'b1111; for the remaining cycles digito SHALL drive bit[index] low, others high.
REQ-019 Content for the slot SHALL be registered at slot cycle 0; segmentos SHALL remain constant for the whole slot.
REQ-020 FSM states: NORMAL (source=0), ALERT (source=1).
REQ-021 A rising alert_req (or high level while none pending) SHALL set a pending flag; further requests while pending SHALL merge into it.
REQ-022 Pending SHALL be serviced only at a frame boundary: latch alert_seg, pulse alert_ack, clear pending, enter ALERT, clear frame count.
REQ-023 In ALERT, frame count SHALL increment per frame boundary; on reaching ALERT_FRAMES with no pending, FSM SHALL return to NORMAL at that boundary.
REQ-024 Pending alert and hold expiry at the same boundary: pending wins; stay ALERT, restart count, ack pulse.
REQ-025 Source changes SHALL occur only at frame boundaries; no frame mixes sources.
REQ-026 Blink phase SHALL toggle every BLINK_FRAMES frames; when blink_en=1, state NORMAL and phase off, digito SHALL be 4'b1111 for the entire frame.
REQ-027 ALERT content SHALL never blink; blink_en=0 SHALL force phase on at the next frame boundary.
REQ-028 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-029 On reset: digito=4'b1111, segmentos=7'b0000000, source=0, alert_ack=0, frame_tick=0.
REQ-030 On reset: slot counter, digit index, frame count, blink counter =0; pending=0; blink phase on; FSM=NORMAL.
REQ-031 Reset asserted mid-alert SHALL drop the alert without ack; first slot after release is digit 0, blanked for BLANK cycles.

Structure
REQ-032 Shared package SHALL hold the FSM state encoding and the 7-bit field width constant.
REQ-033 One sub-module, scan_timer, SHALL contain slot counter, digit index and frame_tick generation.

Verification (SCAN_DIV=8, BLANK=2, ALERT_FRAMES=3, BLINK_FRAMES=2)
REQ-034 Release reset, norm_seg=28'h0A1B2C3 -> digito 1111 for 2 cycles then 1110 for 6, then 1101...; frame_tick every 32 cycles.
REQ-035 alert_req pulse mid-frame -> ack and source=1 exactly at next frame_tick; source back to 0 after 3 further frame_ticks.
REQ-036 alert_req again at frame 3 of hold -> ack at that boundary, source stays 1 for 3 more frames.
REQ-037 blink_en=1 in NORMAL -> 2 frames displayed, 2 frames digito=1111, repeating; during ALERT no blanked frames.
REQ-038 Change norm_seg at slot cycle 4 -> segmentos unchanged until next slot cycle 0.
REQ-039 Assert reset during ALERT -> all outputs at reset values immediately, no ack, source=0 after release.
